hazard_scoreboard: RTL and testbench

- Parametrised RAW-hazard unit for the in-order pipeline; replaces the fixed three-stage rd/rs compare in decode.
- Tracks every in-flight register writer in a DEPTH-entry shift register (entry 0 = EXE, entry DEPTH-1 = WB; the regfile does not write-through).
- Produces decode stall, bubble insertion and branch-flush kill.
- Optionally selects a forwarding source per operand instead of stalling; counts stall cycles for performance analysis.

---
 rtl/hazard_scoreboard.sv | 148 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks in-flight register writers and detects read-after-write hazards
//   for the in-order pipeline. Entry 0 is EXE and entry DEPTH-1 is WB. The
//   register file does not write through, so a writer in WB still blocks a
//   reader. When an instruction cannot issue, the unit stalls decode and
//   inserts a bubble. A taken branch kills the youngest entries. Stall
//   cycles are counted by a saturating counter.
//
//   Build option: define HAZARD_FWD_EN to select a forwarding source per
//   operand instead of stalling whenever that source is ready.
//
// Ports
//   clk_i, rstn_i           clock, synchronous active-low reset
//   issue_valid_i           decode holds a valid instruction
//   rs1/rs2_addr_i, _used_i source operands and their read enables
//   rd_addr_i, rd_we_i      destination of the issuing instruction
//   late_i                  result is produced late (load)
//   flush_i                 taken branch, kill the younger instructions
//   stall_o                 hold fetch/decode and insert a bubble
//   issue_fire_o            instruction enters entry 0 on this edge
//   fwd_rs1/rs2_sel_o       0 = regfile, k = entry k-1
//   busy_o                  at least one valid entry is present
//   stall_count_o           saturating count of stall cycles
module hazard_scoreboard #(
  parameter int DEPTH          = 3,
  parameter int AW             = 5,
  parameter int FLUSH_STAGES   = 2,
  parameter int ALU_FWD_STAGE  = 1,
  parameter int LOAD_FWD_STAGE = 2,
  parameter int CNT_W          = 32
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         issue_valid_i,
  input  logic [AW-1:0]                rs1_addr_i,
  input  logic [AW-1:0]                rs2_addr_i,
  input  logic                         rs1_used_i,
  input  logic                         rs2_used_i,
  input  logic [AW-1:0]                rd_addr_i,
  input  logic                         rd_we_i,
  input  logic                         late_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         issue_fire_o,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs1_sel_o,
  output logic [$clog2(DEPTH+1)-1:0]   fwd_rs2_sel_o,
  output logic                         busy_o,
  output logic [CNT_W-1:0]             stall_count_o
);

  localparam int SELW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] late_q, late_d;
  logic [AW-1:0]    rd_q [DEPTH];
  logic [AW-1:0]    rd_d [DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [DEPTH-1:0] rs1_hit, rs2_hit;
  logic             rs1_haz, rs2_haz;

  // An entry is only ever valid when it writes a non-zero rd, so a valid
  // entry whose rd matches is always a real writer.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs1_hit[i] = valid_q[i] && rs1_used_i && (rs1_addr_i != '0) && (rd_q[i] == rs1_addr_i);
      rs2_hit[i] = valid_q[i] && rs2_used_i && (rs2_addr_i != '0) && (rd_q[i] == rs2_addr_i);
    end
  end

`ifdef HAZARD_FWD_EN
  // Returns {hazard, sel}. The scan runs from oldest to youngest, so the
  // youngest hit decides. An older entry that is ready cannot hide a younger
  // one that is not ready.
  function automatic logic [SELW:0] fwd_pick(input logic [DEPTH-1:0] hit,
                                             input logic [DEPTH-1:0] late);
    logic            haz;
    logic [SELW-1:0] sel;
    haz = 1'b0;
    sel = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (hit[i]) begin
        if (i >= (late[i] ? LOAD_FWD_STAGE : ALU_FWD_STAGE)) begin
          haz = 1'b0;
          sel = SELW'(i + 1);
        end else begin
          haz = 1'b1;
          sel = '0;
        end
      end
    end
    return {haz, sel};
  endfunction

  always_comb begin
    {rs1_haz, fwd_rs1_sel_o} = fwd_pick(rs1_hit, late_q);
    {rs2_haz, fwd_rs2_sel_o} = fwd_pick(rs2_hit, late_q);
  end
`else
  logic unused_fwd;

  assign rs1_haz       = |rs1_hit;
  assign rs2_haz       = |rs2_hit;
  assign fwd_rs1_sel_o = '0;
  assign fwd_rs2_sel_o = '0;
  // Without forwarding, the late flag and the forwarding stages are unused.
  assign unused_fwd    = ^{late_q, (ALU_FWD_STAGE > LOAD_FWD_STAGE)};
`endif

  assign stall_o       = issue_valid_i && (rs1_haz || rs2_haz) && !flush_i;
  assign issue_fire_o  = issue_valid_i && !stall_o && !flush_i;
  assign busy_o        = |valid_q;
  assign stall_count_o = stall_cnt_q;

  always_comb begin
    valid_d[0] = issue_fire_o && rd_we_i && (rd_addr_i != '0);
    rd_d[0]    = rd_addr_i;
    late_d[0]  = late_i;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      rd_d[i]    = rd_q[i-1];
      late_d[i]  = late_q[i-1];
    end
    // The flush kills the youngest entries after they shift in. Older
    // entries keep draining toward WB.
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_i && (i < FLUSH_STAGES)) valid_d[i] = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      valid_q     <= '0;
      late_q      <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      late_q      <= late_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. A driver applies directed and random
// traffic. It uses a reference model of issued writers, each tagged with
// its issue cycle, and pushes the expected outputs for each cycle. A
// monitor then pops those values and compares them with the DUT outputs.
module tb_hazard_scoreboard;

  localparam int DEPTH = 3;
  localparam int FS    = 2;
  localparam int ALU_S = 1;
  localparam int LD_S  = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       iv, u1, u2, we, late, fl;
  logic [4:0] r1, r2, rd;
  logic       stall, fire, busy;
  logic [1:0] s1, s2;
  logic [31:0] cnt;

  hazard_scoreboard dut (
    .clk_i(clk), .rstn_i(rstn), .issue_valid_i(iv),
    .rs1_addr_i(r1), .rs2_addr_i(r2), .rs1_used_i(u1), .rs2_used_i(u2),
    .rd_addr_i(rd), .rd_we_i(we), .late_i(late), .flush_i(fl),
    .stall_o(stall), .issue_fire_o(fire),
    .fwd_rs1_sel_o(s1), .fwd_rs2_sel_o(s2),
    .busy_o(busy), .stall_count_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    logic       late;
    int         cyc;
  } wr_t;

  typedef struct {
    logic        stall, fire, busy;
    logic [1:0]  s1, s2;
    logic [31:0] cnt;
  } exp_t;

  wr_t         live[$];
  exp_t        exp_q[$];
  int          now;
  logic [31:0] m_cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Find the youngest live writer of the operand, then decide whether it
  // stalls or forwards.
  function automatic void opnd(input logic used, input logic [4:0] addr,
                               output logic hz, output logic [1:0] sel);
    int   best;
    logic bl;
    best = -1;
    bl   = 1'b0;
    hz   = 1'b0;
    sel  = 2'd0;
    if (used && addr != 5'd0) begin
      foreach (live[j]) begin
        int k;
        k = now - live[j].cyc - 1;
        if (k >= 0 && k < DEPTH && live[j].rd == addr && (best < 0 || k < best)) begin
          best = k;
          bl   = live[j].late;
        end
      end
    end
    if (best >= 0) begin
`ifdef HAZARD_FWD_EN
      if (best >= (bl ? LD_S : ALU_S)) sel = 2'(best + 1);
      else hz = 1'b1;
`else
      hz = 1'b1;
`endif
    end
  endfunction

  task automatic cyc(input logic i_iv, input logic [4:0] i_r1, input logic i_u1,
                     input logic [4:0] i_r2, input logic i_u2,
                     input logic [4:0] i_rd, input logic i_we, input logic i_late,
                     input logic i_fl, input logic i_rn);
    exp_t e;
    logic h1, h2;
    wr_t  keep[$];
    iv = i_iv; r1 = i_r1; u1 = i_u1; r2 = i_r2; u2 = i_u2;
    rd = i_rd; we = i_we; late = i_late; fl = i_fl; rstn = i_rn;
    opnd(i_u1, i_r1, h1, e.s1);
    opnd(i_u2, i_r2, h2, e.s2);
    e.stall = i_iv && (h1 || h2) && !i_fl;
    e.fire  = i_iv && !e.stall && !i_fl;
    e.busy  = (live.size() != 0);
    e.cnt   = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!i_rn) begin
      live.delete();
      m_cnt = 32'd0;
    end else begin
      if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      keep.delete();
      foreach (live[j]) if (!(i_fl && (now - live[j].cyc) < FS)) keep.push_back(live[j]);
      live = keep;
      if (e.fire && i_we && i_rd != 5'd0) live.push_back('{rd: i_rd, late: i_late, cyc: now});
    end
    now++;
    keep.delete();
    foreach (live[j]) if (now - live[j].cyc - 1 < DEPTH) keep.push_back(live[j]);
    live = keep;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("stall_o", 32'(stall), 32'(e.stall));
        chk("issue_fire_o", 32'(fire), 32'(e.fire));
        chk("fwd_rs1_sel_o", 32'(s1), 32'(e.s1));
        chk("fwd_rs2_sel_o", 32'(s2), 32'(e.s2));
        chk("busy_o", 32'(busy), 32'(e.busy));
        chk("stall_count_o", cnt, e.cnt);
      end
    end
  end

  initial begin
    rstn = 1'b0; iv = 1'b0; u1 = 1'b0; u2 = 1'b0; we = 1'b0; late = 1'b0; fl = 1'b0;
    r1 = 5'd0; r2 = 5'd0; rd = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    now = 0;
    m_cnt = 32'd0;
    live.delete();

    // RAW on rs1 against an ALU writer
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
    repeat (4) cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Load writer
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 1);
    repeat (4) cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // x0 writer and x0 reader; unused rs2
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0, 1);
    cyc(1, 0, 0, 6, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Same register on both operands; rd equals rs on the issuing instruction
    cyc(1, 4, 1, 4, 1, 4, 1, 0, 0, 1);
    repeat (3) cyc(1, 4, 1, 4, 1, 3, 1, 0, 0, 1);
    idle(3);
    // Flush kills the young writer
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 8, 1, 0, 1, 1);
    cyc(1, 7, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(3);
    // Priority: load rd=9 in entry 2, ALU rd=9 in entry 0
    cyc(1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0, 1);
    repeat (4) cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    // Reset held for two edges in the middle of traffic
    cyc(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
    cyc(1, 10, 1, 0, 0, 11, 1, 0, 0, 0);
    cyc(1, 11, 1, 10, 1, 12, 1, 1, 0, 0);
    cyc(1, 10, 1, 11, 1, 0, 0, 0, 0, 1);
    idle(2);

    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 9) < 8),
          5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8),
          5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
          5'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 99) != 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
